// File: rtl/dma_ram_pkg.sv
// Shared constants, FSM state encodings and the tkeep helper for the DMA RAM read stream.
package dma_ram_pkg;

  localparam int DMA_SEG_COUNT    = 2;
  localparam int DMA_SEG_BE_WIDTH = 16;
  localparam int DMA_WORD_BYTES   = DMA_SEG_COUNT * DMA_SEG_BE_WIDTH;
  localparam int MAX_KEEP_WIDTH   = 256;

  typedef logic [1:0] rd_state_t;

  localparam rd_state_t ST_IDLE  = 2'd0;
  localparam rd_state_t ST_ISSUE = 2'd1;
  localparam rd_state_t ST_DRAIN = 2'd2;

  // Low nbytes bits set; callers slice down to their own keep width.
  function automatic logic [MAX_KEEP_WIDTH-1:0] keep_mask(input int unsigned nbytes);
    logic [MAX_KEEP_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
      m[i] = (i < nbytes);
    end
    return m;
  endfunction

endpackage

// File: rtl/dma_ram_rd_seg_fifo.sv
// Per-segment response FIFO with its own read-command credit counter (credits = free rows incl. in flight).
module dma_ram_rd_seg_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_avail,
  input  logic                  rd_pop,
  output logic                  credit_ok,
  input  logic                  cmd_take
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      credit_reg;
  logic                  full;
  logic                  push;

  assign full      = (count_reg == CNT_W'(DEPTH));
  // Held ready through reset so stale responses are flushed rather than stalled.
  assign wr_ready  = rst || !full;
  assign push      = wr_valid && !rst && !full;
  assign rd_avail  = (count_reg != '0);
  assign rd_data   = mem[rd_ptr_reg];
  assign credit_ok = (credit_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      credit_reg <= CNT_W'(DEPTH);
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, rd_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      case ({cmd_take, rd_pop})
        2'b10:   credit_reg <= credit_reg - CNT_W'(1);
        2'b01:   credit_reg <= credit_reg + CNT_W'(1);
        default: credit_reg <= credit_reg;
      endcase
    end
  end

endmodule

// File: rtl/dma_ram_rd_stream.sv
// Segmented DMA RAM read master: descriptor -> per-segment row reads -> full-width AXI-stream beats.
// Optional DMA_RAM_RD_STATUS_EN adds descriptor tag capture and a per-descriptor completion pulse.
module dma_ram_rd_stream
  import dma_ram_pkg::*;
#(
  parameter int SEG_COUNT      = DMA_SEG_COUNT,
  parameter int SEG_DATA_WIDTH = DMA_SEG_BE_WIDTH * 8,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int RAM_ADDR_WIDTH = SEG_ADDR_WIDTH + $clog2(SEG_COUNT * SEG_BE_WIDTH),
  parameter int LEN_WIDTH      = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [RAM_ADDR_WIDTH-1:0]           s_desc_addr,
  input  logic [LEN_WIDTH-1:0]                s_desc_len,
`ifdef DMA_RAM_RD_STATUS_EN
  input  logic [TAG_WIDTH-1:0]                s_desc_tag,
  output logic [TAG_WIDTH-1:0]                m_axis_status_tag,
  output logic                                m_axis_status_valid,
`endif
  input  logic                                s_desc_valid,
  output logic                                s_desc_ready,
  output logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic [SEG_COUNT-1:0]                rd_cmd_valid,
  input  logic [SEG_COUNT-1:0]                rd_cmd_ready,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data,
  input  logic [SEG_COUNT-1:0]                rd_resp_valid,
  output logic [SEG_COUNT-1:0]                rd_resp_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   m_axis_tkeep,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready
);

  localparam int WORD_BYTES = SEG_COUNT * SEG_BE_WIDTH;
  localparam int WB_LOG     = $clog2(WORD_BYTES);
  localparam int KEEP_W     = WORD_BYTES;

  rd_state_t                 state_reg;
  logic [SEG_ADDR_WIDTH-1:0] row_reg;
  logic [LEN_WIDTH-1:0]      rows_left_reg;
  logic [LEN_WIDTH-1:0]      beats_left_reg;
  logic [SEG_COUNT-1:0]      issued_reg;
  logic [KEEP_W-1:0]         last_keep_reg;

  logic                 desc_hs;
  logic                 beat_hs;
  logic                 last_beat;
  logic                 row_done;
  logic [SEG_COUNT-1:0] cmd_hs;
  logic [SEG_COUNT-1:0] seg_avail;
  logic [SEG_COUNT-1:0] seg_credit_ok;
  logic [LEN_WIDTH:0]   len_round;
  logic [LEN_WIDTH-1:0] beats_calc;
  logic [LEN_WIDTH-1:0] len_m1;
  logic [WB_LOG:0]      last_bytes;
  logic                 unused_addr_bits;

  assign unused_addr_bits = &{1'b0, s_desc_addr[WB_LOG-1:0]};

  assign s_desc_ready = !rst && (state_reg == ST_IDLE);
  assign desc_hs      = s_desc_valid && s_desc_ready;
  assign len_round    = {1'b0, s_desc_len} + (LEN_WIDTH+1)'(WORD_BYTES - 1);
  assign beats_calc   = LEN_WIDTH'(len_round >> WB_LOG);
  assign len_m1       = s_desc_len - LEN_WIDTH'(1);
  assign last_bytes   = {1'b0, len_m1[WB_LOG-1:0]} + (WB_LOG+1)'(1);

  assign cmd_hs   = rd_cmd_valid & rd_cmd_ready;
  assign row_done = (state_reg == ST_ISSUE) && (&(issued_reg | cmd_hs));

  // A beat is presented only once every segment holds its part of the row.
  assign m_axis_tvalid = !rst && (&seg_avail);
  assign beat_hs       = m_axis_tvalid && m_axis_tready;
  assign last_beat     = (beats_left_reg == LEN_WIDTH'(1));
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign m_axis_tkeep  = last_beat ? last_keep_reg : {KEEP_W{1'b1}};

  for (genvar gi = 0; gi < SEG_COUNT; gi++) begin : g_seg
    assign rd_cmd_valid[gi] = !rst && (state_reg == ST_ISSUE) && !issued_reg[gi] && seg_credit_ok[gi];
    assign rd_cmd_addr[gi*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH] = row_reg;

    dma_ram_rd_seg_fifo #(
      .DATA_WIDTH (SEG_DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_data   (rd_resp_data[gi*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .wr_valid  (rd_resp_valid[gi]),
      .wr_ready  (rd_resp_ready[gi]),
      .rd_data   (m_axis_tdata[gi*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .rd_avail  (seg_avail[gi]),
      .rd_pop    (beat_hs),
      .credit_ok (seg_credit_ok[gi]),
      .cmd_take  (cmd_hs[gi])
    );
  end

`ifdef DMA_RAM_RD_STATUS_EN
  logic [TAG_WIDTH-1:0] tag_reg;
  logic                 zero_pulse_reg;

  assign m_axis_status_tag   = tag_reg;
  assign m_axis_status_valid = zero_pulse_reg || (beat_hs && last_beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg        <= '0;
      zero_pulse_reg <= 1'b0;
    end else begin
      zero_pulse_reg <= desc_hs && (beats_calc == '0);
      if (desc_hs) begin
        tag_reg <= s_desc_tag;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      row_reg        <= '0;
      rows_left_reg  <= '0;
      beats_left_reg <= '0;
      issued_reg     <= '0;
      last_keep_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (desc_hs) begin
            row_reg        <= s_desc_addr[RAM_ADDR_WIDTH-1:WB_LOG];
            rows_left_reg  <= beats_calc;
            beats_left_reg <= beats_calc;
            issued_reg     <= '0;
            last_keep_reg  <= KEEP_W'(keep_mask(32'(last_bytes)));
            if (beats_calc != '0) begin
              state_reg <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (row_done) begin
            issued_reg    <= '0;
            row_reg       <= row_reg + SEG_ADDR_WIDTH'(1);
            rows_left_reg <= rows_left_reg - LEN_WIDTH'(1);
            if (rows_left_reg == LEN_WIDTH'(1)) begin
              state_reg <= ST_DRAIN;
            end
          end else begin
            issued_reg <= issued_reg | cmd_hs;
          end
        end
        ST_DRAIN: begin
          if (beat_hs && last_beat) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (beat_hs && (state_reg != ST_IDLE)) begin
        beats_left_reg <= beats_left_reg - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dma_ram_rd_stream.sv
// Self-checking bench for dma_ram_rd_stream: RAM model with 2-cycle read pipeline plus a beat scoreboard.
`timescale 1ns/1ps
module tb_dma_ram_rd_stream;

  localparam int SC  = 2;
  localparam int SDW = 128;
  localparam int SAW = 8;
  localparam int RAW = 13;
  localparam int LW  = 16;
  localparam int TW  = 8;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [TW-1:0] tag;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [RAW-1:0]    s_desc_addr = '0;
  logic [LW-1:0]     s_desc_len = '0;
  logic              s_desc_valid = 1'b0;
  logic              s_desc_ready;
  logic [SC*SAW-1:0] rd_cmd_addr;
  logic [SC-1:0]     rd_cmd_valid;
  logic [SC-1:0]     rd_cmd_ready = '0;
  logic [SC*SDW-1:0] rd_resp_data;
  logic [SC-1:0]     rd_resp_valid;
  logic [SC-1:0]     rd_resp_ready;
  logic [255:0]      m_axis_tdata;
  logic [31:0]       m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;
`ifdef DMA_RAM_RD_STATUS_EN
  logic [TW-1:0]     s_desc_tag = '0;
  logic [TW-1:0]     m_axis_status_tag;
  logic              m_axis_status_valid;
`endif

  dma_ram_rd_stream #(
    .SEG_COUNT(SC), .SEG_DATA_WIDTH(SDW), .SEG_ADDR_WIDTH(SAW), .LEN_WIDTH(LW),
    .FIFO_DEPTH(4), .TAG_WIDTH(TW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_desc_addr         (s_desc_addr),
    .s_desc_len          (s_desc_len),
`ifdef DMA_RAM_RD_STATUS_EN
    .s_desc_tag          (s_desc_tag),
    .m_axis_status_tag   (m_axis_status_tag),
    .m_axis_status_valid (m_axis_status_valid),
`endif
    .s_desc_valid        (s_desc_valid),
    .s_desc_ready        (s_desc_ready),
    .rd_cmd_addr         (rd_cmd_addr),
    .rd_cmd_valid        (rd_cmd_valid),
    .rd_cmd_ready        (rd_cmd_ready),
    .rd_resp_data        (rd_resp_data),
    .rd_resp_valid       (rd_resp_valid),
    .rd_resp_ready       (rd_resp_ready),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tkeep        (m_axis_tkeep),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tready       (m_axis_tready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RAM contents and cycle counter for the read-latency model
  logic [SDW-1:0] ram [SC][256];
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < SC; gi++) begin : g_ram
    logic [SDW-1:0] dq[$];
    longint         tq[$];
    logic           rv = 1'b0;
    logic [SDW-1:0] rdv = '0;
    assign rd_resp_valid[gi] = rv;
    assign rd_resp_data[gi*SDW +: SDW] = rdv;
    always @(posedge clk) begin
      if (rst) begin
        dq.delete();
        tq.delete();
        rv <= 1'b0;
      end else begin
        if (rv && rd_resp_ready[gi]) begin
          void'(dq.pop_front());
          void'(tq.pop_front());
        end
        if (rd_cmd_valid[gi] && rd_cmd_ready[gi]) begin
          dq.push_back(ram[gi][rd_cmd_addr[gi*SAW +: SAW]]);
          tq.push_back(cyc + 2);
        end
        if (dq.size() > 0 && tq[0] <= cyc + 1) begin
          rv  <= 1'b1;
          rdv <= dq[0];
        end else begin
          rv <= 1'b0;
        end
      end
    end
  end

  // Handshake-pressure driver, controlled by modes set from the main sequence
  int          tready_mode = 0;
  bit          cmd_rand = 1'b0;
  logic [SC-1:0] cmd_hold = '0;
  always @(posedge clk) begin
    #1;
    case (tready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ($urandom_range(3) != 0);
    endcase
    for (int s = 0; s < SC; s++) begin
      rd_cmd_ready[s] = cmd_hold[s] ? 1'b0 : (cmd_rand ? ($urandom_range(2) != 0) : 1'b1);
    end
  end

  // Scoreboard and monitor
  beat_t        exp_q[$];
  int           beat_cnt = 0;
  int           cmd_cnt [SC];
  logic         stall_prev = 1'b0;
  logic [255:0] stall_data = '0;
  logic [31:0]  last_keep_seen = '0;

  initial for (int s = 0; s < SC; s++) cmd_cnt[s] = 0;

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_tvalid", 256'(m_axis_tvalid), 256'(1));
        chk("stall_tdata", m_axis_tdata, stall_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 256'(m_axis_tvalid), 256'(0));
        end else begin
          b = exp_q.pop_front();
          chk("beat_tdata", m_axis_tdata, b.data);
          chk("beat_tkeep", 256'(m_axis_tkeep), 256'(b.keep));
          chk("beat_tlast", 256'(m_axis_tlast), 256'(b.last));
`ifdef DMA_RAM_RD_STATUS_EN
          chk("status_valid", 256'(m_axis_status_valid), 256'(b.last));
          if (b.last) chk("status_tag", 256'(m_axis_status_tag), 256'(b.tag));
`endif
          $display("[TB] beat %0d data=%h keep=%h last=%0d", beat_cnt, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
          beat_cnt++;
          if (m_axis_tlast) last_keep_seen = m_axis_tkeep;
        end
      end
      for (int s = 0; s < SC; s++) begin
        if (rd_cmd_valid[s] && rd_cmd_ready[s]) cmd_cnt[s]++;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
    end
  end

  // Reference model: expected beats straight from address/length arithmetic
  task automatic model_desc(input int addr, input int len, input logic [TW-1:0] t);
    beat_t b;
    int row0 = addr / 32;
    int nb = (len + 31) / 32;
    int tail = len - 32 * (nb - 1);
    for (int i = 0; i < nb; i++) begin
      int r = (row0 + i) % 256;
      b.data = {ram[1][r], ram[0][r]};
      b.last = (i == nb - 1);
      b.keep = '0;
      for (int k = 0; k < 32; k++) b.keep[k] = b.last ? (k < tail) : 1'b1;
      b.tag = t;
      exp_q.push_back(b);
    end
  endtask

  task automatic submit(input int addr, input int len, input logic [TW-1:0] t);
    int n = 0;
    @(posedge clk); #1;
    s_desc_addr  = RAW'(addr);
    s_desc_len   = LW'(len);
    s_desc_valid = 1'b1;
`ifdef DMA_RAM_RD_STATUS_EN
    s_desc_tag = t;
`endif
    while (1) begin
      @(negedge clk);
      if (s_desc_ready) break;
      n++;
      if (n > 2000) begin
        chk("desc_accept_timeout", 256'(s_desc_ready), 256'(1));
        break;
      end
    end
    model_desc(addr, len, t);
    $display("[TB] descriptor addr=0x%0h len=%0d tag=0x%0h", addr, len, t);
    @(posedge clk); #1;
    s_desc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (n < 4000) begin
      @(negedge clk);
      if (exp_q.size() == 0 && s_desc_ready) break;
      n++;
    end
    if (n >= 4000) chk({tag, "_timeout"}, 256'(exp_q.size() == 0 && s_desc_ready), 256'(1));
  endtask

  initial begin
    int b0, c0, c1;
    for (int s = 0; s < SC; s++)
      for (int r = 0; r < 256; r++)
        ram[s][r] = {$urandom, $urandom, $urandom, $urandom};

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_desc_ready", 256'(s_desc_ready), 256'(0));
    chk("rst_resp_ready", 256'(rd_resp_ready), 256'(2'b11));
    chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("rst_cmd_valid", 256'(rd_cmd_valid), 256'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_desc_ready", 256'(s_desc_ready), 256'(1));
    chk("post_rst_tlast", 256'(m_axis_tlast), 256'(0));
    tready_mode = 1;

    // two full beats from row 0
    b0 = beat_cnt;
    submit(0, 64, 8'h11);
    @(negedge clk);
    chk("t1_first_cmd_valid", 256'(rd_cmd_valid), 256'(2'b11));
    chk("t1_first_cmd_addr", 256'(rd_cmd_addr), 256'(16'h0000));
    wait_done("t1");
    chk("t1_beats", 256'(beat_cnt - b0), 256'(2));

    // partial last beat
    b0 = beat_cnt;
    submit('h40, 40, 8'h22);
    wait_done("t2");
    chk("t2_beats", 256'(beat_cnt - b0), 256'(2));
    chk("t2_last_keep", 256'(last_keep_seen), 256'(32'h0000_00FF));

    // row wrap 255 -> 0
    submit('h1FE0, 64, 8'h33);
    @(negedge clk);
    chk("t3_cmd_row255", 256'(rd_cmd_addr), 256'(16'hFFFF));
    @(negedge clk);
    chk("t3_cmd_row0", 256'(rd_cmd_addr), 256'(16'h0000));
    chk("t3_cmd_valid_row0", 256'(rd_cmd_valid), 256'(2'b11));
    wait_done("t3");

    // backpressure: rows in flight bounded by FIFO depth
    @(negedge clk);
    tready_mode = 0;
    c0 = cmd_cnt[0];
    c1 = cmd_cnt[1];
    b0 = beat_cnt;
    submit(0, 1024, 8'h44);
    repeat (20) @(negedge clk);
    chk("t4_rows_seg0", 256'(cmd_cnt[0] - c0), 256'(4));
    chk("t4_rows_seg1", 256'(cmd_cnt[1] - c1), 256'(4));
    chk("t4_no_more_cmd", 256'(rd_cmd_valid), 256'(0));
    tready_mode = 1;
    wait_done("t4");
    chk("t4_beats", 256'(beat_cnt - b0), 256'(32));

    // segment 1 command stalled, segment 0 proceeds
    @(negedge clk);
    cmd_hold = 2'b10;
    repeat (2) @(posedge clk);
    c0 = cmd_cnt[0];
    c1 = cmd_cnt[1];
    b0 = beat_cnt;
    submit(0, 128, 8'h55);
    repeat (5) @(negedge clk);
    chk("t5_seg0_issued", 256'(cmd_cnt[0] - c0), 256'(1));
    chk("t5_seg1_stalled", 256'(cmd_cnt[1] - c1), 256'(0));
    chk("t5_cmd_valid", 256'(rd_cmd_valid), 256'(2'b10));
    cmd_hold = 2'b00;
    wait_done("t5");
    chk("t5_beats", 256'(beat_cnt - b0), 256'(4));

    // reset mid-transfer
    submit('h100, 256, 8'h66);
    repeat (4) @(negedge clk);
    tready_mode = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_desc_ready", 256'(s_desc_ready), 256'(0));
    chk("t6_rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("t6_rst_cmd_valid", 256'(rd_cmd_valid), 256'(0));
    chk("t6_rst_resp_ready", 256'(rd_resp_ready), 256'(2'b11));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_post_desc_ready", 256'(s_desc_ready), 256'(1));
    chk("t6_post_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("t6_post_tlast", 256'(m_axis_tlast), 256'(0));
    tready_mode = 1;
    b0 = beat_cnt;
    submit('h3A0, 32, 8'h77);
    wait_done("t6_clean");
    chk("t6_clean_beats", 256'(beat_cnt - b0), 256'(1));

    // zero length: no beat, status pulse only
    b0 = beat_cnt;
    submit('h200, 0, 8'h5A);
`ifdef DMA_RAM_RD_STATUS_EN
    @(negedge clk);
    chk("t7_status_valid", 256'(m_axis_status_valid), 256'(1));
    chk("t7_status_tag", 256'(m_axis_status_tag), 256'(8'h5A));
`endif
    repeat (5) @(negedge clk);
    chk("t7_no_beat", 256'(beat_cnt - b0), 256'(0));
    chk("t7_desc_ready", 256'(s_desc_ready), 256'(1));

    // randomized descriptors under random backpressure
    tready_mode = 2;
    cmd_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int a = $urandom_range(0, 8191);
      int l = (i == 3) ? 0 : $urandom_range(1, 400);
      submit(a, l, TW'(i));
      wait_done("rand");
    end
    chk("final_queue_empty", 256'(exp_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
